// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// sequencer states and the decoded-control bundle.
package cu_pkg;

  localparam int CU_OPC_W = 4;
  localparam int CU_ALU_W = 4;

  localparam logic [CU_OPC_W-1:0] OP_ADD   = 4'h0;
  localparam logic [CU_OPC_W-1:0] OP_SUB   = 4'h1;
  localparam logic [CU_OPC_W-1:0] OP_AND   = 4'h2;
  localparam logic [CU_OPC_W-1:0] OP_OR    = 4'h3;
  localparam logic [CU_OPC_W-1:0] OP_ADDI  = 4'h4;
  localparam logic [CU_OPC_W-1:0] OP_LOAD  = 4'h5;
  localparam logic [CU_OPC_W-1:0] OP_STORE = 4'h6;
  localparam logic [CU_OPC_W-1:0] OP_NOP   = 4'hE;
  localparam logic [CU_OPC_W-1:0] OP_HALT  = 4'hF;

  localparam logic [CU_ALU_W-1:0] ALU_ADD = 4'h0;
  localparam logic [CU_ALU_W-1:0] ALU_SUB = 4'h1;
  localparam logic [CU_ALU_W-1:0] ALU_AND = 4'h2;
  localparam logic [CU_ALU_W-1:0] ALU_OR  = 4'h3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [CU_ALU_W-1:0] alu_control;
    logic                alu_src_imm;
    logic                is_mem;
    logic                is_store;
    logic                is_load;
    logic                writes_reg;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the sequencer and the instruction memory, data memory, ALU and
// register file. Requests are held high until the matching ready is seen.
interface multicycle_control_unit_if #(
  parameter int INSTR_W    = 16,
  parameter int ALU_CTRL_W = 4
);
  logic [INSTR_W-1:0]    instr;
  logic                  imem_ready;
  logic                  imem_req;
  logic                  ir_load;
  logic                  pc_inc;
  logic                  dmem_ready;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  alu_src_imm;
  logic                  reg_write;
  logic                  wb_sel;
  logic                  halted;
  logic                  illegal;
  logic                  mem_fault;

  modport master (
    input  instr, imem_ready, dmem_ready,
    output imem_req, ir_load, pc_inc, dmem_req, dmem_we, alu_control,
           alu_src_imm, reg_write, wb_sel, halted, illegal, mem_fault
  );

  modport slave (
    output instr, imem_ready, dmem_ready,
    input  imem_req, ir_load, pc_inc, dmem_req, dmem_we, alu_control,
           alu_src_imm, reg_write, wb_sel, halted, illegal, mem_fault
  );
endinterface

// File: rtl/cu_decoder.sv
// Purely combinational opcode decoder producing the per-instruction control
// bundle; undefined opcodes only raise the illegal flag.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OPCODE_W'(OP_ADD): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OPCODE_W'(OP_SUB): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OPCODE_W'(OP_AND): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_control = ALU_AND;
      end
      OPCODE_W'(OP_OR): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_control = ALU_OR;
      end
      OPCODE_W'(OP_ADDI): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      // Address generation for memory ops reuses ADD with the immediate.
      OPCODE_W'(OP_LOAD): begin
        ctrl.writes_reg  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.is_mem      = 1'b1;
        ctrl.is_load     = 1'b1;
      end
      OPCODE_W'(OP_STORE): begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.is_mem      = 1'b1;
        ctrl.is_store    = 1'b1;
      end
      OPCODE_W'(OP_NOP), OPCODE_W'(OP_HALT): ;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with request/ready
// handshakes to both memories and a bounded data-memory wait.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPCODE_W    = 4,
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_unit_if.master  bus,
  output state_t                     dbg_state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [INSTR_W-1:0]  ir;
  logic [OPCODE_W-1:0] opcode;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout;
  logic                fault_set;
  logic                mem_fault_q;
  logic                hold_ctrl;
  ctrl_t               ctrl;
  logic                unused_ir_bits;

  assign opcode         = ir[INSTR_W-1 -: OPCODE_W];
  assign unused_ir_bits = ^ir[INSTR_W-OPCODE_W-1:0];
  assign cnt_inc        = cnt + 1'b1;
  // The last allowed MEM cycle is the one whose increment reaches the limit;
  // a ready in that same cycle still completes the access.
  assign timeout        = (cnt_inc == CNT_W'(MEM_TIMEOUT));
  assign hold_ctrl      = (state == S_EXECUTE) || (state == S_MEM) ||
                          (state == S_WRITEBACK);
  assign dbg_state      = state;
  assign bus.mem_fault  = mem_fault_q;

  cu_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      ir          <= '0;
      cnt         <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (bus.ir_load) ir <= bus.instr;
      cnt         <= (state == S_MEM) ? cnt_inc : '0;
      mem_fault_q <= fault_set;
    end
  end

  always_comb begin
    state_nxt       = state;
    fault_set       = 1'b0;
    bus.imem_req    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.alu_control = '0;
    bus.alu_src_imm = 1'b0;
    bus.reg_write   = 1'b0;
    bus.wb_sel      = 1'b0;
    bus.halted      = 1'b0;
    bus.illegal     = 1'b0;

    if (hold_ctrl) begin
      bus.alu_control = ALU_CTRL_W'(ctrl.alu_control);
      bus.alu_src_imm = ctrl.alu_src_imm;
      bus.wb_sel      = ctrl.is_load;
    end

    case (state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_load = 1'b1;
          bus.pc_inc  = 1'b1;
          state_nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ctrl.illegal) begin
          bus.illegal = 1'b1;
          state_nxt   = S_FETCH;
        end else if (ctrl.is_mem || ctrl.writes_reg) begin
          state_nxt = S_EXECUTE;
        end else if (opcode == OPCODE_W'(OP_HALT)) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_EXECUTE: state_nxt = ctrl.is_mem ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = ctrl.is_store;
        if (bus.dmem_ready) begin
          state_nxt = ctrl.is_load ? S_WRITEBACK : S_FETCH;
        end else if (timeout) begin
          fault_set = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        bus.reg_write = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus random instruction
// streams compared against a per-instruction timing/strobe summary model.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int ALU_CTRL_W = 4;
  localparam int T          = 15;
  localparam int NF         = 15;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  multicycle_control_unit_if #(.INSTR_W(INSTR_W), .ALU_CTRL_W(ALU_CTRL_W)) bus ();

  multicycle_control_unit #(
    .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W),
    .ALU_CTRL_W(ALU_CTRL_W), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          obs[NF];
  string       names[NF] = '{"cycles", "ir_load_n", "pc_inc_n", "ir_cyc", "imem_req_n",
                             "reg_write_n", "wr_cyc", "wb_sel_wr", "alu_wr", "src_wr",
                             "dmem_req_n", "dmem_we_n", "mem_src", "illegal_n", "fault_n"};

  task automatic chk(input string tag, input logic [31:0] o);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic [13:0] out_vec();
    return {bus.ir_load, bus.pc_inc, bus.dmem_req, bus.dmem_we, bus.alu_control,
            bus.alu_src_imm, bus.reg_write, bus.wb_sel, bus.halted, bus.illegal,
            bus.mem_fault};
  endfunction

  // Reference: what one instruction should look like from outside, derived
  // from the opcode table, cycle counts and wait rules alone.
  task automatic model(input logic [3:0] op, input int iw, input int dw);
    bit is_alu, is_addi, is_ld, is_st, is_ill, is_mem, ok, writes;
    int base, cycles, req;
    logic [3:0] alu;
    is_alu  = (op <= 4'h3);
    is_addi = (op == 4'h4);
    is_ld   = (op == 4'h5);
    is_st   = (op == 4'h6);
    is_ill  = (op >= 4'h7) && (op <= 4'hD);
    is_mem  = is_ld || is_st;
    ok      = (dw < T);
    writes  = is_alu || is_addi || (is_ld && ok);
    base    = iw + 1;
    if (is_alu || is_addi) cycles = base + 3;
    else if (is_ld)        cycles = ok ? base + dw + 4 : base + 2 + T;
    else if (is_st)        cycles = ok ? base + dw + 3 : base + 2 + T;
    else                   cycles = base + 1;
    req = is_mem ? (ok ? dw + 1 : T) : 0;
    alu = (op == 4'h1) ? 4'h1 : (op == 4'h2) ? 4'h2 : (op == 4'h3) ? 4'h3 : 4'h0;
    exp_q.push_back(cycles);
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(base);
    exp_q.push_back(base);
    exp_q.push_back(writes ? 1 : 0);
    exp_q.push_back(writes ? cycles : 0);
    exp_q.push_back((writes && is_ld) ? 1 : 0);
    exp_q.push_back(writes ? alu : 4'h0);
    exp_q.push_back((writes && (is_addi || is_ld)) ? 1 : 0);
    exp_q.push_back(req);
    exp_q.push_back(is_st ? req : 0);
    exp_q.push_back(is_mem ? 1 : 0);
    exp_q.push_back(is_ill ? 1 : 0);
    exp_q.push_back((is_mem && !ok) ? 1 : 0);
  endtask

  // ---------------- driver ----------------
  // Entered at a falling edge during the first FETCH cycle of the instruction;
  // returns at the falling edge of the following FETCH (or first HALT) cycle.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw);
    int cyc   = 0;
    int iwl   = iw;
    int dseen = 0;
    bit fetched = 0;
    bit fin     = 0;
    for (int k = 0; k < NF; k++) obs[k] = 0;
    while (!fin) begin
      if (fetched && (bus.imem_req || bus.halted)) begin
        if (bus.mem_fault) obs[14]++;
        fin = 1;
      end else begin
        cyc++;
        if (bus.imem_req) begin
          bus.instr = ins;
          if (iwl > 0) begin
            bus.imem_ready = 1'b0;
            iwl--;
          end else begin
            bus.imem_ready = 1'b1;
          end
        end else begin
          bus.imem_ready = 1'($urandom_range(0, 1));
          bus.instr      = 16'($urandom);
        end
        if (bus.dmem_req) begin
          bus.dmem_ready = (dseen == dw);
          dseen++;
        end else begin
          bus.dmem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        obs[0] = cyc;
        if (bus.ir_load) begin obs[1]++; obs[3] = cyc; fetched = 1; end
        if (bus.pc_inc) obs[2]++;
        if (bus.imem_req) obs[4]++;
        if (bus.reg_write) begin
          obs[5]++;
          obs[6] = cyc;
          obs[7] = int'(bus.wb_sel);
          obs[8] = int'(bus.alu_control);
          obs[9] = int'(bus.alu_src_imm);
        end
        if (bus.dmem_req) begin
          obs[10]++;
          if (bus.dmem_we) obs[11]++;
          obs[12] = int'(bus.alu_src_imm);
        end
        if (bus.illegal) obs[13]++;
        if (bus.mem_fault && cyc > 1) obs[14]++;
        if (cyc > 200) begin
          checks++;
          errors++;
          $error("FAIL instr_timeout observed=%0d expected<=200", cyc);
          fin = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_instr(input logic [15:0] ins, input int iw, input int dw);
    run_instr(ins, iw, dw);
    model(ins[15:12], iw, dw);
    for (int k = 0; k < NF; k++) chk($sformatf("%s_op%0h", names[k], ins[15:12]), obs[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_a, cnt_b, cnt_c;
    logic [3:0] op;
    rst = 1'b1;
    bus.instr = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(1);  chk("reset_imem_req", bus.imem_req);
    exp_q.push_back(0);  chk("reset_outputs", out_vec());
    exp_q.push_back(S_FETCH); chk("reset_state", dbg_state);
    @(negedge clk);

    check_instr(16'h0123, 0, 0);          // ADD, memory always ready
    check_instr(16'h5A42, 0, 3);          // LOAD, three wait cycles
    check_instr(16'h6311, 0, T + 5);      // STORE, dmem never ready
    check_instr(16'h7000, 0, 0);          // illegal
    check_instr(16'h1234, 0, 0);          // SUB
    check_instr(16'h5001, 2, T - 1);      // LOAD, ready on the last allowed cycle
    check_instr(16'h6FFF, 1, 0);          // STORE, zero wait
    check_instr(16'hE000, 0, 0);          // NOP
    check_instr(16'h2F0F, 3, 0);          // AND
    check_instr(16'h3ABC, 0, 0);          // OR
    check_instr(16'h4007, 1, 0);          // ADDI

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 14));
      check_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, T + 2));
    end

    // Reset while ADDI sits in EXECUTE.
    bus.instr = 16'h4ABC;
    bus.imem_ready = 1'b1;
    #1;
    exp_q.push_back(1); chk("addi_ir_load", bus.ir_load);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    #1;
    exp_q.push_back(1); chk("addi_exec_src_imm", bus.alu_src_imm);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(1); chk("abort_imem_req", bus.imem_req);
    exp_q.push_back(0); chk("abort_outputs", out_vec());
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.reg_write || bus.dmem_req || bus.pc_inc) cnt_a++;
    end
    exp_q.push_back(0); chk("abort_strobes", cnt_a);
    @(negedge clk);

    // HALT: stays put regardless of ready inputs until reset.
    check_instr(16'hF000, 0, 0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 20; c++) begin
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      #1;
      if (bus.halted) cnt_a++;
      if (bus.imem_req) cnt_b++;
      if ({bus.ir_load, bus.pc_inc, bus.dmem_req, bus.reg_write, bus.illegal} != 0) cnt_c++;
      @(negedge clk);
    end
    exp_q.push_back(20); chk("halt_halted_n", cnt_a);
    exp_q.push_back(0);  chk("halt_imem_req_n", cnt_b);
    exp_q.push_back(0);  chk("halt_strobes_n", cnt_c);
    exp_q.push_back(S_HALT); chk("halt_state", dbg_state);
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(0); chk("post_halt_halted", bus.halted);
    exp_q.push_back(1); chk("post_halt_imem_req", bus.imem_req);
    @(negedge clk);
    check_instr(16'h0042, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle combinational control unit of the CPU_LOAD core. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with ready/request handshakes to instruction and data memory. Adds LOAD/STORE, immediate ALU ops, HALT, illegal-opcode detection and a bounded memory-wait timeout. Sits between the instruction memory, register file, ALU and data memory as the core's sole sequencer.

## Interface
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: OPCODE_W]
- OPCODE_W, 4, opcode field width
- ALU_CTRL_W, 4, width of alu_control
- MEM_TIMEOUT, 15, max cycles to wait for dmem_ready (>=1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  INSTR_W  instruction word from instruction memory
- imem_ready  in  1  instruction memory data valid
- imem_req  out  1  instruction fetch request
- ir_load  out  1  one-cycle pulse: latch instr into IR
- pc_inc  out  1  one-cycle pulse: advance PC
- dmem_ready  in  1  data memory access complete
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (valid with dmem_req)
- alu_control  out  ALU_CTRL_W  ALU operation select
- alu_src_imm  out  1  ALU B operand = immediate
- reg_write  out  1  one-cycle register-file write strobe
- wb_sel  out  1  writeback source: 0 ALU, 1 memory
- halted  out  1  core halted
- illegal  out  1  one-cycle pulse on undefined opcode
- mem_fault  out  1  one-cycle pulse on data-memory timeout

## Operation
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, ADDI 0100, LOAD 0101, STORE 0110, NOP 1110, HALT 1111; all others illegal.
- alu_control: ADD/ADDI/LOAD/STORE 0000, SUB 0001, AND 0010, OR 0011, else 0000.
- Internal IR (INSTR_W) captured on ir_load; decode uses IR only, never live instr.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: imem_req=1 until imem_ready; on imem_ready: ir_load=1, pc_inc=1, -> DECODE.
- DECODE: ALU ops/ADDI/LOAD/STORE -> EXECUTE; NOP -> FETCH; HALT -> HALT; illegal -> illegal=1, -> FETCH (treated as NOP).
- EXECUTE: alu_control and alu_src_imm (1 for ADDI/LOAD/STORE) driven; ALU ops -> WRITEBACK; LOAD/STORE -> MEM.
- MEM: dmem_req=1, dmem_we=1 for STORE; wait counter increments per cycle. On dmem_ready: LOAD -> WRITEBACK, STORE -> FETCH. If counter reaches MEM_TIMEOUT without dmem_ready: mem_fault=1, dmem_req drops, -> FETCH, no reg_write.
- WRITEBACK: reg_write=1 for one cycle; wb_sel=1 for LOAD else 0; -> FETCH.
- HALT: halted=1, all strobes/requests 0; exit only via rst.
- alu_control/alu_src_imm/wb_sel held from EXECUTE through WRITEBACK for the current instruction.

## Timing
- Reset: state=FETCH, IR=0, counter=0; all outputs 0 on the first cycle after reset (imem_req rises in FETCH combinationally from state).
- Outputs are Moore (decoded from state + IR) except ir_load/pc_inc, which are gated by imem_ready in FETCH.
- With zero-wait memory: ALU op 4 cycles, LOAD 5, STORE 4, NOP/illegal 2.
- Each wait cycle on imem_ready/dmem_ready adds exactly one cycle.
- dmem_ready asserted on the same cycle the counter hits MEM_TIMEOUT: ready wins, no fault.
- imem_ready/dmem_ready ignored outside FETCH/MEM.
- rst mid-instruction: return to FETCH next cycle; no reg_write, dmem_req or pc_inc from the aborted instruction.
- Wait counter clears on MEM entry; width $clog2(MEM_TIMEOUT+1).

## Structure
- Package cu_pkg: opcode localparams, state enum, ALU control codes, decoded-control struct (alu_control, alu_src_imm, is_mem, is_store, is_load, writes_reg, illegal).
- Sub-module cu_decoder: purely combinational IR opcode -> control struct; FSM, IR and wait counter stay in multicycle_control_unit.

## Test plan
- Reset then ADD (0x0123), imem_ready=1, held high -> ir_load/pc_inc at cycle 1, reg_write at cycle 4, alu_control=0000, wb_sel=0.
- LOAD (0x5xxx), dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, reg_write with wb_sel=1, alu_src_imm=1.
- STORE (0x6xxx), dmem_ready never -> dmem_req for MEM_TIMEOUT cycles, mem_fault pulse, back to FETCH, no reg_write.
- Opcode 0x7 then SUB (0x1xxx) -> illegal pulse once, no reg_write for 0x7; SUB completes with alu_control=0001.
- HALT (0xF000) -> halted=1, imem_req=0 for 20 cycles despite imem_ready; rst -> halted=0, FETCH resumes.
- rst asserted in EXECUTE of ADDI (0x4xxx) -> next cycle all outputs 0 except imem_req; no reg_write observed.
